// File: rtl/uart_rx.sv
// 8N1 UART receiver running from a 16x-oversampling baud strobe.
// Synchronises rx, centres on each bit and reports bytes or stop-bit framing errors.
module uart_rx #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 baud_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_error,
    output logic                 busy
);

    localparam int CNT_W  = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int BIDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CNT_W-1:0]  HALF_TICK = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0]  LAST_TICK = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIDX_W-1:0] LAST_BIT  = BIDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } state_t;

    state_t                 state, state_nxt;
    logic                   rx_meta, rx_s;
    logic [CNT_W-1:0]       tick_cnt, tick_nxt;
    logic [BIDX_W-1:0]      bit_idx, idx_nxt;
    logic [DATA_BITS-1:0]   shift_reg, shift_nxt;
    logic [DATA_BITS-1:0]   data_nxt;
    logic                   valid_nxt, ferr_nxt;

    // Idle-high reset value keeps a released reset from looking like a start bit.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            tick_cnt    <= '0;
            bit_idx     <= '0;
            shift_reg   <= '0;
            data        <= '0;
            data_valid  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_nxt;
            tick_cnt    <= tick_nxt;
            bit_idx     <= idx_nxt;
            shift_reg   <= shift_nxt;
            data        <= data_nxt;
            data_valid  <= valid_nxt;
            frame_error <= ferr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        tick_nxt  = tick_cnt;
        idx_nxt   = bit_idx;
        shift_nxt = shift_reg;
        data_nxt  = data;
        valid_nxt = 1'b0;
        ferr_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (baud_tick && !rx_s) begin
                    state_nxt = START;
                    tick_nxt  = '0;
                end
            end
            START: begin
                if (baud_tick) begin
                    if (tick_cnt == HALF_TICK) begin
                        // A start bit that is high again at its centre was noise.
                        if (rx_s) begin
                            state_nxt = IDLE;
                        end else begin
                            state_nxt = DATA;
                            tick_nxt  = '0;
                            idx_nxt   = '0;
                        end
                    end else begin
                        tick_nxt = tick_cnt + CNT_W'(1);
                    end
                end
            end
            DATA: begin
                if (baud_tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        shift_nxt                = shift_reg >> 1;
                        shift_nxt[DATA_BITS-1]   = rx_s;
                        tick_nxt                 = '0;
                        if (bit_idx == LAST_BIT) state_nxt = STOP;
                        else                     idx_nxt   = bit_idx + BIDX_W'(1);
                    end else begin
                        tick_nxt = tick_cnt + CNT_W'(1);
                    end
                end
            end
            STOP: begin
                if (baud_tick) begin
                    if (tick_cnt == LAST_TICK) begin
                        tick_nxt = '0;
                        if (rx_s) begin
                            data_nxt  = shift_reg;
                            valid_nxt = 1'b1;
                            state_nxt = IDLE;
                        end else begin
                            ferr_nxt  = 1'b1;
                            state_nxt = BREAK;
                        end
                    end else begin
                        tick_nxt = tick_cnt + CNT_W'(1);
                    end
                end
            end
            BREAK: begin
                // Line held low must return high before another start is accepted.
                if (rx_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Randomised scoreboard bench for uart_rx: driver pushes expected bytes/errors,
// a negedge monitor pops and compares whenever a pulse appears.
module tb_uart_rx;
    localparam int OS   = 16;
    localparam int DB   = 8;
    localparam int TDIV = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          baud_tick = 1'b0;
    logic          rx = 1'b1;
    logic [DB-1:0] data;
    logic          data_valid, frame_error, busy;

    uart_rx #(.DATA_BITS(DB), .OVERSAMPLE(OS)) dut (
        .clk(clk), .reset(reset), .baud_tick(baud_tick), .rx(rx),
        .data(data), .data_valid(data_valid), .frame_error(frame_error), .busy(busy)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    bit tick_rand = 1'b1;
    int tick_ctr  = 0;
    always begin
        @(posedge clk);
        #1;
        if (tick_rand) baud_tick = 1'($urandom_range(0, 1));
        else begin
            baud_tick = (tick_ctr == TDIV - 1);
            tick_ctr  = (tick_ctr + 1) % TDIV;
        end
    end

    typedef struct {
        bit            ferr;
        logic [DB-1:0] b;
    } exp_t;
    exp_t          exp_q[$];
    logic [DB-1:0] last_good = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Wait for n baud ticks as the DUT sees them, then step away from the edge.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
        #2;
    endtask

    task automatic send_bit(input logic v, input int n);
        rx = v;
        wait_ticks(n);
    endtask

    // Reference: a good frame yields its byte; a low stop bit yields an error
    // with the previously received byte still on data.
    task automatic send_frame(input logic [DB-1:0] b, input logic stop, input bit push);
        exp_t e;
        if (push) begin
            e.ferr = !stop;
            if (stop) last_good = b;
            e.b = last_good;
            exp_q.push_back(e);
        end
        send_bit(1'b0, OS);
        for (int i = 0; i < DB; i++) send_bit(b[i], OS);
        send_bit(stop, OS);
    endtask

    bit prev_pulse = 1'b0;
    bit prev_tick  = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (data_valid || frame_error) begin
            check("pulse_exclusive", 32'(data_valid && frame_error), 0);
            check("pulse_one_cycle", 32'(prev_pulse), 0);
            check("pulse_after_tick", 32'(prev_tick), 1);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got dv=%0b fe=%0b data=%0h expected none", data_valid, frame_error, data);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind_ferr", 32'(frame_error), 32'(e.ferr));
                check("pulse_data", 32'(data), 32'(e.b));
            end
        end
        prev_pulse = data_valid || frame_error;
        prev_tick  = baud_tick;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $display("[TB] %0d tests run, %0d failed", tests + 1, fails + 1);
        $fatal(1, "timeout");
    end

    initial begin
        logic [DB-1:0] b;
        logic [DB-1:0] m;
        // Reset with random ticks and idle line
        reset = 1'b0; rx = 1'b1; tick_rand = 1'b1;
        repeat (20) @(posedge clk);
        #2;
        check("rst_data", 32'(data), 0);
        check("rst_valid", 32'(data_valid), 0);
        check("rst_ferr", 32'(frame_error), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b1; tick_rand = 1'b0;
        repeat (40) @(posedge clk);
        #2;
        check("idle_busy", 32'(busy), 0);
        check("idle_data", 32'(data), 0);

        // Single byte
        send_frame(8'h55, 1'b1, 1'b1);
        check("single_busy_after", 32'(busy), 0);
        check("single_drained", 32'(exp_q.size()), 0);
        send_bit(1'b1, 5);

        // Back-to-back, no idle gap
        send_frame(8'hA5, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        check("b2b_drained", 32'(exp_q.size()), 0);
        check("b2b_data", 32'(data), 32'h3C);
        send_bit(1'b1, 5);

        // Glitch on the start bit
        send_bit(1'b0, 4);
        check("glitch_busy_high", 32'(busy), 1);
        send_bit(1'b1, 8);
        check("glitch_busy_low", 32'(busy), 0);
        check("glitch_data", 32'(data), 32'h3C);
        send_bit(1'b1, 10);

        // Framing error then line break
        send_frame(8'h12, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b0, 1'b1);
        send_bit(1'b0, 40);
        check("break_busy", 32'(busy), 1);
        check("break_data", 32'(data), 32'h12);
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("break_release", 32'(busy), 0);
        send_bit(1'b1, 3);
        send_frame(8'h81, 1'b1, 1'b1);
        send_bit(1'b1, 5);

        // Reset asserted in the middle of data bit 3
        b = 8'h5A;
        send_bit(1'b0, OS);
        for (int i = 0; i < 3; i++) send_bit(b[i], OS);
        send_bit(b[3], OS / 2);
        reset = 1'b0;
        #1;
        check("midrst_data", 32'(data), 0);
        check("midrst_valid", 32'(data_valid), 0);
        check("midrst_ferr", 32'(frame_error), 0);
        check("midrst_busy", 32'(busy), 0);
        last_good = '0;
        rx = 1'b1;
        repeat (8) @(posedge clk);
        #2;
        reset = 1'b1;
        send_bit(1'b1, 20);
        send_frame(8'h3E, 1'b1, 1'b1);
        check("midrst_recover", 32'(data), 32'h3E);

        // Random frames, random gaps and phase, occasional bad stop bit
        for (int n = 0; n < 30; n++) begin
            b = 8'($urandom);
            m = 8'($urandom_range(0, 9));
            repeat ($urandom_range(0, TDIV - 1)) @(posedge clk);
            #2;
            if (m == 0) begin
                send_frame(b, 1'b0, 1'b1);
                send_bit(1'b0, $urandom_range(0, 20));
                send_bit(1'b1, $urandom_range(1, 10));
            end else begin
                send_frame(b, 1'b1, 1'b1);
                if ($urandom_range(0, 1) == 1) send_bit(1'b1, $urandom_range(1, 10));
            end
        end
        send_bit(1'b1, 4);

        for (int i = 0; i < 1000 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        check("final_drained", 32'(exp_q.size()), 0);
        check("final_busy", 32'(busy), 0);
        check("final_data", 32'(data), 32'(last_good));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
8N1 UART receiver driven by the design's 16x-oversampling baud tick. The tick source is a one-clk-wide strobe at 16 x baud, nominally 9600 baud from 16.5 MHz. The block synchronises the serial rx line, detects start bits and samples each bit at mid-period. It delivers received bytes to the core with a one-cycle valid strobe and flags stop-bit framing errors.

Parameters:
DATA_BITS, 8, number of data bits per frame, LSB first
OVERSAMPLE, 16, baud ticks per bit period; must be even and at least 4

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
baud_tick  input  1  oversample strobe, high for exactly one clk cycle, OVERSAMPLE per bit
rx  input  1  serial line, asynchronous to clk, idle high
data  output  DATA_BITS  last correctly framed byte, held until the next good frame
data_valid  output  1  one-clk pulse: data just updated
frame_error  output  1  one-clk pulse: stop bit sampled low
busy  output  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (async, active-low): data=0, data_valid=0, frame_error=0, busy=0, FSM=IDLE, both synchroniser flops=1, counters=0. Reset asserted mid-frame aborts the frame with no pulse.
- rx passes through a 2-flop synchroniser (rx_s); all decisions use rx_s only, giving 2 clk of latency.
- tick_cnt is log2(OVERSAMPLE) bits wide and advances only on baud_tick cycles.
- With no baud_tick, the FSM and counters are frozen.
- IDLE: on baud_tick with rx_s=0 -> START, tick_cnt=0.
- START: on each tick, tick_cnt++.
  - On the tick where tick_cnt==OVERSAMPLE/2-1 (mid start bit), sample rx_s.
  - rx_s=1 (glitch) -> IDLE, no pulses.
  - rx_s=0 -> DATA, tick_cnt=0, bit_idx=0.
- DATA: on each tick, tick_cnt++.
  - On the tick where tick_cnt==OVERSAMPLE-1, shift rx_s into the MSB of shift_reg (right shift, LSB-first line order) and set tick_cnt=0.
  - If bit_idx==DATA_BITS-1 -> STOP, else bit_idx++.
- STOP: on the tick where tick_cnt==OVERSAMPLE-1, sample rx_s.
  - rx_s=1: data<=shift_reg, data_valid=1 for the next clk cycle only -> IDLE.
  - rx_s=0: frame_error=1 for the next clk cycle only, data unchanged -> BREAK.
- BREAK: wait until rx_s=1 (checked every clk, tick not required) -> IDLE. A line held low never produces a spurious start.
- Output latency: data, data_valid and frame_error are registered and change on the clk edge after the sampling tick's edge.
- data_valid and frame_error are never high together and never high for two consecutive cycles.
- busy is high in START, DATA, STOP and BREAK; low in IDLE.
- Back-to-back frames: returning to IDLE at mid stop bit lets a start edge immediately after the stop bit be detected with no idle gap required.
- Start detection resolution is one tick, so the sample point lands within +/-1 tick of true mid-bit.

Test Plan:
- Reset: hold reset=0 with rx=1 and random baud_tick -> data=0x00, data_valid=0, frame_error=0, busy=0; release -> all outputs stay 0 while rx idles high.
- Single byte: tick every 4 clk, send 0x55 8N1 at 16 ticks/bit -> exactly one data_valid pulse one clk after the stop-bit mid tick, data=0x55, frame_error never 1, busy low afterwards.
- Back-to-back: send 0xA5 then 0x3C with no idle between the stop and start bits -> two data_valid pulses, data=0xA5 then 0x3C.
- Glitch: drive rx low for 4 ticks, then high -> busy pulses high, returns to 0 by tick 8, no data_valid, no frame_error, data unchanged.
- Framing/break: receive 0x12, then send 0xFF with stop bit=0 and hold rx low for 40 more ticks -> one frame_error pulse, no data_valid, data stays 0x12, busy high until rx returns high. Then send 0x81 -> data_valid with data=0x81.
- Reset mid-frame: assert reset during data bit 3 -> outputs 0 immediately (asynchronously), busy=0. Release and send 0x3E -> data=0x3E with a single data_valid, no error.
